// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - sizing constants and types for the rename free list
package free_list_pkg;

  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;
  localparam int FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int PIDX_W       = $clog2(NUM_PHYS_REG);
  localparam int FL_IDX_W     = $clog2(FL_DEPTH);
  localparam int FL_PTR_W     = FL_IDX_W + 1;

  typedef logic [PIDX_W-1:0]   pidx_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;

  localparam fl_ptr_t FL_PTR_ONE  = fl_ptr_t'(1);
  localparam fl_ptr_t FL_PTR_FULL = fl_ptr_t'(FL_DEPTH);
  localparam pidx_t   FL_CNT_MAX  = pidx_t'(FL_DEPTH);

  // Storage slot addressed by a pointer (drops the wrap bit).
  function automatic fl_idx_t ptr_idx(input fl_ptr_t p);
    return p[FL_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free physical register indices
module free_list
  import free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enqueue,
  input  logic [PIDX_W-1:0] pd_free,
  input  logic              dequeue,
  output logic [PIDX_W-1:0] pd_alloc,
  output logic              empty,
  output logic              full,
  input  logic              flush,
  output logic [PIDX_W-1:0] count
);

  pidx_t   mem_q [FL_DEPTH];
  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  logic    deq_eff;

  // Status is purely a function of the pointers; pd_alloc is show-ahead.
  always_comb begin
    empty    = (head_q == tail_q);
    full     = (ptr_idx(head_q) == ptr_idx(tail_q)) &&
               (head_q[FL_PTR_W-1] != tail_q[FL_PTR_W-1]);
    count    = pidx_t'(tail_q - head_q);
    pd_alloc = mem_q[ptr_idx(head_q)];
  end

  // Pointer next state. On flush every pd not in the committed map is free
  // again, so head is placed exactly one lap behind the post-enqueue tail.
  always_comb begin
    deq_eff = dequeue && !empty && !flush;
    tail_d  = enqueue ? (tail_q + FL_PTR_ONE) : tail_q;
    head_d  = head_q;
    if (flush) begin
      head_d = {~tail_d[FL_PTR_W-1], tail_d[FL_PTR_W-2:0]};
    end else if (deq_eff) begin
      head_d = head_q + FL_PTR_ONE;
    end
  end

  // State update; reset reloads the initial image of pds NUM_ARCH_REG..
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= FL_PTR_FULL;
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= pidx_t'(NUM_ARCH_REG + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (enqueue) begin
        mem_q[ptr_idx(tail_q)] <= pd_free;
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks on the retirement side and occupancy sanity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enqueue && full))
        else $error("free_list: enqueue while full");
      assert (!(enqueue && pd_free == '0))
        else $error("free_list: pd 0 freed");
      assert (count <= FL_CNT_MAX)
        else $error("free_list: count above depth");
    end
  end
`endif

endmodule
